// File: rtl/ascon_pkg.sv
// Shared Ascon types, permutation FSM encoding and round-function helpers.
package ascon_pkg;

    localparam int NUM_WORDS        = 5;
    localparam int WORD_WIDTH       = 64;
    localparam int ASCON_MAX_ROUNDS = 16;
    localparam int ASCON_P8         = 8;
    localparam int ASCON_P12        = 12;

    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ascon_perm_fsm_t;

    // Round constant for round-index slot idx; slot 4 holds the first p[12] constant (0xf0),
    // so p[12] walks slots 4..15 (0xf0..0x4b) and p[8] walks slots 8..15 (0xb4..0x4b).
    function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
        logic [3:0] i;
        i = idx - 4'd4;
        return {4'd15 - i, i};
    endfunction

    function automatic logic [WORD_WIDTH-1:0] ror64(input logic [WORD_WIDTH-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_WIDTH - n));
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once.
    function automatic ascon_state_t ascon_sbox(input ascon_state_t s);
        logic [WORD_WIDTH-1:0] x0, x1, x2, x3, x4;
        logic [WORD_WIDTH-1:0] t0, t1, t2, t3, t4;
        ascon_state_t r;
        x0 = s[0] ^ s[4];
        x1 = s[1];
        x2 = s[2] ^ s[1];
        x3 = s[3];
        x4 = s[4] ^ s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0;
        r[1] = x1;
        r[2] = x2;
        r[3] = x3;
        r[4] = x4;
        return r;
    endfunction

    function automatic ascon_state_t ascon_linear(input ascon_state_t s);
        ascon_state_t r;
        r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        r[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
        r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        r[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
        return r;
    endfunction

endpackage

// File: rtl/ascon_permutation_ctrl_round.sv
// One combinational Ascon round: constant addition, substitution layer, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state,
    input  logic [7:0]   rc,
    output ascon_state_t result
);

    ascon_state_t added_s;
    ascon_state_t subst_s;

    // Constant addition into the low byte of word 2.
    always_comb begin
        added_s       = state;
        added_s[2][7:0] = state[2][7:0] ^ rc;
    end

    // Substitution layer.
    always_comb begin
        subst_s = ascon_sbox(added_s);
    end

    // Linear diffusion.
    always_comb begin
        result = ascon_linear(subst_s);
    end

endmodule

// File: rtl/ascon_permutation_ctrl.sv
// Ascon-p[8]/p[12] permutation sequencer with valid/ready input and output handshakes.
// Optional ASCON_PERM_UNROLL2_EN chains two rounds per cycle (half latency, same results).
module ascon_permutation_ctrl
    import ascon_pkg::*;
#(
    parameter int RND_IDX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  ascon_state_t state_i,
    input  logic         rnd_sel_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

`ifdef ASCON_PERM_UNROLL2_EN
    localparam logic [RND_IDX_W-1:0] IDX_STEP = RND_IDX_W'(2);
    localparam logic [RND_IDX_W-1:0] IDX_LAST = RND_IDX_W'(ASCON_MAX_ROUNDS - 2);
`else
    localparam logic [RND_IDX_W-1:0] IDX_STEP = RND_IDX_W'(1);
    localparam logic [RND_IDX_W-1:0] IDX_LAST = RND_IDX_W'(ASCON_MAX_ROUNDS - 1);
`endif

    ascon_perm_fsm_t        fsm_r;
    ascon_state_t           state_r;
    logic [RND_IDX_W-1:0]   idx_r;
    logic                   out_valid_r;
    logic                   busy_r;

    logic [RND_IDX_W-1:0]   idx_init_s;
    logic [7:0]             rc0_s;
    ascon_state_t           round0_s;
    ascon_state_t           next_state_s;

    ascon_round u_round0 (
        .state  (state_r),
        .rc     (rc0_s),
        .result (round0_s)
    );

`ifdef ASCON_PERM_UNROLL2_EN
    logic [7:0]             rc1_s;
    ascon_state_t           round1_s;

    ascon_round u_round1 (
        .state  (round0_s),
        .rc     (rc1_s),
        .result (round1_s)
    );

    // Constants and next state for a chained round pair.
    always_comb begin
        rc0_s        = ascon_rc(idx_r);
        rc1_s        = ascon_rc(idx_r + RND_IDX_W'(1));
        next_state_s = round1_s;
    end
`else
    // Constant and next state for a single round.
    always_comb begin
        rc0_s        = ascon_rc(idx_r);
        next_state_s = round0_s;
    end
`endif

    // Starting slot so that every permutation ends on slot 15.
    always_comb begin
        if (rnd_sel_i) begin
            idx_init_s = RND_IDX_W'(ASCON_MAX_ROUNDS - ASCON_P12);
        end else begin
            idx_init_s = RND_IDX_W'(ASCON_MAX_ROUNDS - ASCON_P8);
        end
    end

    // Accept is combinational from out_ready_i so DONE can hand straight over to RUN.
    assign in_ready_o  = (fsm_r == IDLE) | ((fsm_r == DONE) & out_ready_i);
    assign out_valid_o = out_valid_r;
    assign busy_o      = busy_r;
    assign state_o     = state_r;

    // Permutation FSM with registered status outputs and state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_r       <= IDLE;
            state_r     <= '0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid_i) begin
                        state_r <= state_i;
                        idx_r   <= idx_init_s;
                        busy_r  <= 1'b1;
                        fsm_r   <= RUN;
                    end
                end
                RUN: begin
                    state_r <= next_state_s;
                    if (idx_r == IDX_LAST) begin
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        fsm_r       <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_STEP;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_r <= 1'b0;
                        if (in_valid_i) begin
                            state_r <= state_i;
                            idx_r   <= idx_init_s;
                            busy_r  <= 1'b1;
                            fsm_r   <= RUN;
                        end else begin
                            fsm_r <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
